// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants and the sync-monitor state type.
// Used by the sync monitor, the display controller and benches.
package vga_timing_pkg;

    localparam int CORDW       = 10;
    localparam int H_TOTAL     = 800;
    localparam int V_TOTAL     = 525;
    localparam int LOCK_FRAMES = 2;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        ALIGN  = 2'd1,
        LOCKED = 2'd2
    } sync_state_t;

endpackage

// File: rtl/sync_edge_det.sv
// Falling-edge detector for an active-low sync, sampled only on enable cycles.
// fall_o is combinational from the enable cycle; the sample register resets high.
module sync_edge_det (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic en_i,
    input  logic sig_i,
    output logic fall_o
);

    logic sig_q;
    logic sig_d;

    always_comb begin
        sig_d = en_i ? sig_i : sig_q;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sig_q <= 1'b1;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign fall_o = en_i & sig_q & ~sig_i;

endmodule

// File: rtl/vga_sync_monitor.sv
// Recovers pixel/line position from incoming VGA syncs, measures line/frame size
// and locks after LOCK_FRAMES consecutive frames matching H_TOTAL x V_TOTAL.
module vga_sync_monitor #(
    parameter int CORDW       = vga_timing_pkg::CORDW,
    parameter int H_TOTAL     = vga_timing_pkg::H_TOTAL,
    parameter int V_TOTAL     = vga_timing_pkg::V_TOTAL,
    parameter int LOCK_FRAMES = vga_timing_pkg::LOCK_FRAMES
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             pix_en,
    input  logic             hSync,
    input  logic             vSync,
    output logic [CORDW-1:0] rx_hc,
    output logic [CORDW-1:0] rx_vc,
    output logic [CORDW-1:0] line_len,
    output logic [CORDW-1:0] frame_lines,
    output logic             locked,
    output logic             frame_done,
    output logic             line_err,
    output logic             frame_err,
    output logic             timeout
);

    import vga_timing_pkg::*;

    localparam int GW = (LOCK_FRAMES < 2) ? 1 : $clog2(LOCK_FRAMES + 1);
    localparam logic [CORDW-1:0] CMAX = '1;

    logic hfall;
    logic vfall;

    sync_edge_det u_hs_det (
        .clk_i   (Clk),
        .rst_n_i (Reset_n),
        .en_i    (pix_en),
        .sig_i   (hSync),
        .fall_o  (hfall)
    );

    sync_edge_det u_vs_det (
        .clk_i   (Clk),
        .rst_n_i (Reset_n),
        .en_i    (pix_en),
        .sig_i   (vSync),
        .fall_o  (vfall)
    );

    sync_state_t      state_q, state_d;
    logic [GW-1:0]    good_cnt_q, good_cnt_d;
    logic [CORDW-1:0] rx_hc_q, rx_hc_d;
    logic [CORDW-1:0] rx_vc_q, rx_vc_d;
    logic [CORDW-1:0] line_len_q, line_len_d;
    logic [CORDW-1:0] frame_lines_q, frame_lines_d;
    logic             locked_q, locked_d;
    logic             frame_done_q, frame_done_d;
    logic             line_err_q, line_err_d;
    logic             frame_err_q, frame_err_d;
    logic             timeout_q, timeout_d;
    logic             seen_h_q, seen_h_d;
    logic             to_armed_q, to_armed_d;
    logic             ferr_q, ferr_d;

    logic [CORDW:0]   hc_plus1;
    logic [CORDW:0]   vc_sum;
    logic [CORDW-1:0] hc_inc_sat;
    logic [CORDW-1:0] vc_inc_sat;
    logic [GW:0]      good_inc;
    logic             checking;

    // Measurement datapath; every update below already implies pix_en.
    always_comb begin
        hc_plus1   = {1'b0, rx_hc_q} + (CORDW+1)'(1);
        vc_sum     = {1'b0, rx_vc_q} + (CORDW+1)'(hfall);
        hc_inc_sat = (rx_hc_q == CMAX) ? CMAX : rx_hc_q + CORDW'(1);
        vc_inc_sat = (rx_vc_q == CMAX) ? CMAX : rx_vc_q + CORDW'(1);
        checking   = (state_q != SEARCH);

        line_err_d   = hfall & seen_h_q & checking & (hc_plus1 != (CORDW+1)'(H_TOTAL));
        frame_err_d  = vfall & checking & (vc_sum != (CORDW+1)'(V_TOTAL));
        frame_done_d = vfall;
        timeout_d    = pix_en & ~hfall & to_armed_q & (hc_inc_sat == CMAX);

        rx_hc_d       = rx_hc_q;
        rx_vc_d       = rx_vc_q;
        line_len_d    = line_len_q;
        frame_lines_d = frame_lines_q;

        if (pix_en) begin
            rx_hc_d = hfall ? '0 : hc_inc_sat;
        end
        if (hfall) begin
            line_len_d = hc_plus1[CORDW] ? CMAX : hc_plus1[CORDW-1:0];
        end
        if (vfall) begin
            rx_vc_d       = '0;
            frame_lines_d = vc_sum[CORDW] ? CMAX : vc_sum[CORDW-1:0];
        end else if (hfall) begin
            rx_vc_d = vc_inc_sat;
        end

        // A line is only judged once a full line has been observed since reset/timeout.
        seen_h_d = seen_h_q;
        if (timeout_d) begin
            seen_h_d = 1'b0;
        end else if (hfall) begin
            seen_h_d = 1'b1;
        end

        to_armed_d = to_armed_q;
        if (hfall) begin
            to_armed_d = 1'b1;
        end else if (timeout_d) begin
            to_armed_d = 1'b0;
        end
    end

    // Lock FSM: ferr_q remembers any bad line seen within the current frame.
    always_comb begin
        state_d    = state_q;
        good_cnt_d = good_cnt_q;
        good_inc   = {1'b0, good_cnt_q} + (GW+1)'(1);
        ferr_d     = ferr_q | line_err_d;
        if (vfall) begin
            ferr_d = 1'b0;
        end

        if (timeout_d) begin
            state_d    = SEARCH;
            good_cnt_d = '0;
            ferr_d     = 1'b0;
        end else begin
            case (state_q)
                SEARCH: begin
                    if (vfall) begin
                        state_d    = ALIGN;
                        good_cnt_d = '0;
                    end
                end
                ALIGN: begin
                    if (vfall) begin
                        if (ferr_q || line_err_d || frame_err_d) begin
                            good_cnt_d = '0;
                        end else begin
                            good_cnt_d = good_inc[GW-1:0];
                            if (good_inc >= (GW+1)'(LOCK_FRAMES)) begin
                                state_d = LOCKED;
                            end
                        end
                    end
                end
                LOCKED: begin
                    if (line_err_d || frame_err_d) begin
                        state_d    = ALIGN;
                        good_cnt_d = '0;
                    end
                end
                default: begin
                    state_d    = SEARCH;
                    good_cnt_d = '0;
                end
            endcase
        end

        locked_d = (state_d == LOCKED);
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q       <= SEARCH;
            good_cnt_q    <= '0;
            rx_hc_q       <= '0;
            rx_vc_q       <= '0;
            line_len_q    <= '0;
            frame_lines_q <= '0;
            locked_q      <= 1'b0;
            frame_done_q  <= 1'b0;
            line_err_q    <= 1'b0;
            frame_err_q   <= 1'b0;
            timeout_q     <= 1'b0;
            seen_h_q      <= 1'b0;
            to_armed_q    <= 1'b1;
            ferr_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            good_cnt_q    <= good_cnt_d;
            rx_hc_q       <= rx_hc_d;
            rx_vc_q       <= rx_vc_d;
            line_len_q    <= line_len_d;
            frame_lines_q <= frame_lines_d;
            locked_q      <= locked_d;
            frame_done_q  <= frame_done_d;
            line_err_q    <= line_err_d;
            frame_err_q   <= frame_err_d;
            timeout_q     <= timeout_d;
            seen_h_q      <= seen_h_d;
            to_armed_q    <= to_armed_d;
            ferr_q        <= ferr_d;
        end
    end

    assign rx_hc       = rx_hc_q;
    assign rx_vc       = rx_vc_q;
    assign line_len    = line_len_q;
    assign frame_lines = frame_lines_q;
    assign locked      = locked_q;
    assign frame_done  = frame_done_q;
    assign line_err    = line_err_q;
    assign frame_err   = frame_err_q;
    assign timeout     = timeout_q;

endmodule

// File: tb/tb_vga_sync_monitor.sv
// Bench for vga_sync_monitor with scaled-down timing (40 ticks x 12 lines)
// so whole frames fit a short run; pix_en is one Clk in every four.
module tb_vga_sync_monitor;

    localparam int CW   = 10;
    localparam int TB_H = 40;
    localparam int TB_V = 12;
    localparam int HS_W = 4;
    localparam int VS_W = 2;

    logic          Clk = 1'b0;
    logic          Reset_n;
    logic          pix_en;
    logic          hSync;
    logic          vSync;
    logic [CW-1:0] rx_hc;
    logic [CW-1:0] rx_vc;
    logic [CW-1:0] line_len;
    logic [CW-1:0] frame_lines;
    logic          locked;
    logic          frame_done;
    logic          line_err;
    logic          frame_err;
    logic          timeout;

    vga_sync_monitor #(
        .CORDW       (CW),
        .H_TOTAL     (TB_H),
        .V_TOTAL     (TB_V),
        .LOCK_FRAMES (2)
    ) dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .pix_en      (pix_en),
        .hSync       (hSync),
        .vSync       (vSync),
        .rx_hc       (rx_hc),
        .rx_vc       (rx_vc),
        .line_len    (line_len),
        .frame_lines (frame_lines),
        .locked      (locked),
        .frame_done  (frame_done),
        .line_err    (line_err),
        .frame_err   (frame_err),
        .timeout     (timeout)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;

    int n_line_err = 0, n_frame_err = 0, n_timeout = 0;
    int err_line_len = -1, err_locked = -1, to_rx_hc = -1, to_locked = -1;

    always @(posedge Clk) begin
        #1;
        if (line_err) begin
            n_line_err++;
            err_line_len = int'(line_len);
            err_locked   = int'(locked);
        end
        if (frame_err) n_frame_err++;
        if (timeout) begin
            n_timeout++;
            to_rx_hc  = int'(rx_hc);
            to_locked = int'(locked);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_rx_hc"},       int'(rx_hc),       0);
        check({tag, "_rx_vc"},       int'(rx_vc),       0);
        check({tag, "_line_len"},    int'(line_len),    0);
        check({tag, "_frame_lines"}, int'(frame_lines), 0);
        check({tag, "_locked"},      int'(locked),      0);
        check({tag, "_frame_done"},  int'(frame_done),  0);
        check({tag, "_line_err"},    int'(line_err),    0);
        check({tag, "_frame_err"},   int'(frame_err),   0);
        check({tag, "_timeout"},     int'(timeout),     0);
    endtask

    // Async reset pulse issued between clock edges; outputs checked before any edge.
    task automatic do_reset(input string tag);
        pix_en = 1'b0;
        #2 Reset_n = 1'b0;
        #1 check_zero(tag);
        @(negedge Clk);
        Reset_n = 1'b1;
    endtask

    task automatic tick(input logic hs, input logic vs);
        repeat (3) @(negedge Clk);
        pix_en = 1'b1;
        hSync  = hs;
        vSync  = vs;
        @(negedge Clk);
        pix_en = 1'b0;
    endtask

    task automatic line_ticks(input int v, input int h0, input int h1);
        for (int h = h0; h < h1; h++) begin
            tick((h < HS_W) ? 1'b0 : 1'b1, (v < VS_W) ? 1'b0 : 1'b1);
        end
    endtask

    // Everything of a frame except its opening hSync/vSync fall.
    task automatic frame_body(input int nlines, input int bad_line, input int bad_len);
        line_ticks(0, 1, TB_H);
        for (int v = 1; v < nlines; v++) begin
            line_ticks(v, 0, (v == bad_line) ? bad_len : TB_H);
        end
    endtask

    task automatic edge_tick();
        tick(1'b0, 1'b0);
    endtask

    task automatic good_frame();
        frame_body(TB_V, -1, 0);
        edge_tick();
    endtask

    typedef struct {
        logic pe, hs, vs;
        int   hc, vc, ll, fl;
        logic fd, le, fe;
    } vec_t;

    vec_t tbl[12];

    int base_le, base_fe, base_to;

    initial begin
        // pe hs vs | rx_hc rx_vc line_len frame_lines | frame_done line_err frame_err
        tbl[0]  = '{1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 1'b1, 0, 1, 1, 0, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 1'b1, 1'b1, 1, 1, 1, 0, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 1'b1, 1'b1, 2, 1, 1, 0, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 2, 1, 1, 0, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 1'b1, 0, 2, 3, 0, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 1'b0, 1'b1, 1, 2, 3, 0, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 1'b1, 1'b0, 2, 0, 3, 2, 1'b1, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 0, 1, 3, 2, 1'b0, 1'b1, 1'b0};
        tbl[9]  = '{1'b1, 1'b1, 1'b1, 1, 1, 3, 2, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 0, 0, 2, 2, 1'b1, 1'b1, 1'b1};
        tbl[11] = '{1'b0, 1'b1, 1'b1, 0, 0, 2, 2, 1'b0, 1'b0, 1'b0};

        pix_en  = 1'b0;
        hSync   = 1'b1;
        vSync   = 1'b1;
        Reset_n = 1'b1;
        #1 Reset_n = 1'b0;
        #1 check_zero("por");
        @(negedge Clk);
        @(negedge Clk);
        Reset_n = 1'b1;

        // Per-Clk edge detection and counter vectors
        for (int i = 0; i < 12; i++) begin
            pix_en = tbl[i].pe;
            hSync  = tbl[i].hs;
            vSync  = tbl[i].vs;
            @(negedge Clk);
            check($sformatf("vec%0d_rx_hc", i),       int'(rx_hc),       tbl[i].hc);
            check($sformatf("vec%0d_rx_vc", i),       int'(rx_vc),       tbl[i].vc);
            check($sformatf("vec%0d_line_len", i),    int'(line_len),    tbl[i].ll);
            check($sformatf("vec%0d_frame_lines", i), int'(frame_lines), tbl[i].fl);
            check($sformatf("vec%0d_frame_done", i),  int'(frame_done),  int'(tbl[i].fd));
            check($sformatf("vec%0d_line_err", i),    int'(line_err),    int'(tbl[i].le));
            check($sformatf("vec%0d_frame_err", i),   int'(frame_err),   int'(tbl[i].fe));
            check($sformatf("vec%0d_locked", i),      int'(locked),      0);
        end
        pix_en = 1'b0;

        // Nominal lock: locked after the 3rd vfall
        do_reset("rst1");
        base_le = n_line_err;
        base_fe = n_frame_err;
        edge_tick();
        check("nom_vf1_frame_done", int'(frame_done), 1);
        check("nom_vf1_locked",     int'(locked),     0);
        good_frame();
        check("nom_vf2_locked",      int'(locked),      0);
        check("nom_vf2_line_len",    int'(line_len),    TB_H);
        check("nom_vf2_frame_lines", int'(frame_lines), TB_V);
        check("nom_vf2_rx_vc",       int'(rx_vc),       0);
        check("nom_vf2_rx_hc",       int'(rx_hc),       0);
        good_frame();
        check("nom_vf3_locked",      int'(locked),      1);
        check("nom_vf3_frame_done",  int'(frame_done),  1);
        check("nom_vf3_line_len",    int'(line_len),    TB_H);
        check("nom_vf3_frame_lines", int'(frame_lines), TB_V);
        check("nom_line_err_cnt",    n_line_err - base_le,  0);
        check("nom_frame_err_cnt",   n_frame_err - base_fe, 0);

        // One short line while locked, then relock after two good frames
        base_le = n_line_err;
        frame_body(TB_V, 5, TB_H - 1);
        check("short_line_err_cnt", n_line_err - base_le, 1);
        check("short_line_len",     err_line_len, TB_H - 1);
        check("short_locked_at_err", err_locked, 0);
        edge_tick();
        check("short_vf1_locked", int'(locked), 0);
        good_frame();
        check("short_vf2_locked", int'(locked), 0);
        good_frame();
        check("short_vf3_locked", int'(locked), 1);
        check("short_frame_err_cnt", n_frame_err - base_fe, 0);

        // Frame one line short while locked: frame_err, back to ALIGN (relock in 2)
        base_le = n_line_err;
        frame_body(TB_V - 1, -1, 0);
        edge_tick();
        check("sframe_frame_err",   int'(frame_err),   1);
        check("sframe_frame_lines", int'(frame_lines), TB_V - 1);
        check("sframe_locked",      int'(locked),      0);
        good_frame();
        check("sframe_vf2_locked", int'(locked), 0);
        good_frame();
        check("sframe_vf3_locked", int'(locked), 1);
        check("sframe_line_err_cnt", n_line_err - base_le, 0);

        // pix_en stalled mid-line
        line_ticks(0, 1, TB_H);
        for (int v = 1; v < 4; v++) line_ticks(v, 0, TB_H);
        line_ticks(4, 0, 10);
        check("stall_pre_rx_hc", int'(rx_hc), 9);
        check("stall_pre_rx_vc", int'(rx_vc), 4);
        repeat (50) @(negedge Clk);
        check("stall_rx_hc",  int'(rx_hc),  9);
        check("stall_rx_vc",  int'(rx_vc),  4);
        check("stall_locked", int'(locked), 1);
        line_ticks(4, 10, 11);
        check("stall_resume_rx_hc", int'(rx_hc), 10);
        line_ticks(4, 11, TB_H);
        for (int v = 5; v < TB_V; v++) line_ticks(v, 0, TB_H);
        edge_tick();
        check("stall_vf_locked",      int'(locked),      1);
        check("stall_vf_frame_lines", int'(frame_lines), TB_V);
        check("stall_line_err_cnt",   n_line_err - base_le, 0);

        // Reset mid-line while locked, relock on 3rd vfall after release
        line_ticks(0, 1, TB_H);
        for (int v = 1; v < 5; v++) line_ticks(v, 0, TB_H);
        line_ticks(5, 0, 15);
        check("mid_pre_locked", int'(locked), 1);
        do_reset("rst_mid");
        base_le = n_line_err;
        base_fe = n_frame_err;
        line_ticks(5, 15, TB_H);
        for (int v = 6; v < TB_V; v++) line_ticks(v, 0, TB_H);
        edge_tick();
        check("rst_vf1_locked", int'(locked), 0);
        good_frame();
        check("rst_vf2_locked", int'(locked), 0);
        good_frame();
        check("rst_vf3_locked", int'(locked), 1);
        check("rst_line_err_cnt",  n_line_err - base_le,  0);
        check("rst_frame_err_cnt", n_frame_err - base_fe, 0);

        // hSync stuck high: single timeout, drop to SEARCH
        base_to = n_timeout;
        base_fe = n_frame_err;
        base_le = n_line_err;
        for (int i = 0; i < 1024; i++) tick(1'b1, 1'b1);
        check("to_rx_hc",       int'(rx_hc),        1023);
        check("to_cnt",         n_timeout - base_to, 1);
        check("to_rx_hc_pulse", to_rx_hc,            1023);
        check("to_locked",      int'(locked),        0);
        check("to_locked_pulse", to_locked,          0);
        for (int i = 0; i < 20; i++) tick(1'b1, 1'b1);
        check("to_single_cnt", n_timeout - base_to, 1);
        tick(1'b0, 1'b1);
        check("to_hfall_rx_hc", int'(rx_hc), 0);
        for (int i = 0; i < 5; i++) tick(1'b1, 1'b1);
        edge_tick();
        check("to_search_frame_lines", int'(frame_lines), 2);
        check("to_search_frame_err",   n_frame_err - base_fe, 0);
        check("to_search_line_err",    n_line_err - base_le,  0);
        check("to_search_locked",      int'(locked), 0);
        for (int i = 0; i < 1024; i++) tick(1'b1, 1'b1);
        check("to_rearm_cnt", n_timeout - base_to, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
